// File: rtl/alu_if.sv
// Operand/result handshake bundle for alu_pipe.
// The master side produces operands and consumes results; the slave side is the ALU.
interface alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [3:0]       flag;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, opcode, in_valid, out_ready,
        input  in_ready, x, flag, out_valid
    );

    modport slave (
        input  a, b, opcode, in_valid, out_ready,
        output in_ready, x, flag, out_valid
    );
endinterface

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshake; opcode 7 runs an iterative
// shift-add multiply that occupies the block for WIDTH cycles.
//
// state | meaning
// IDLE  | no result held, ready for an operation
// BUSY  | multiply iterating, one partial-product bit per cycle
// HOLD  | result presented on x/flag until the consumer takes it
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int M  = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t             state, state_nxt;
    logic               in_ready_i;
    logic               out_valid_i;
    logic               accept;
    logic               transfer;
    logic               mul_start;
    logic               alu_load;
    logic               mul_done;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_x;
    logic               alu_c;
    logic               alu_v;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   x_q;
    logic [3:0]         flag_q;

    // HOLD can take a new operation in the same cycle its result is consumed
    assign in_ready_i  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    assign out_valid_i = (state == HOLD);
    assign accept      = bus.in_valid && in_ready_i;
    assign transfer    = out_valid_i && bus.out_ready;
    assign mul_start   = accept && (bus.opcode == 3'd7);
    assign alu_load    = accept && (bus.opcode != 3'd7);
    assign mul_done    = (state == BUSY) && (cnt == '0);

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_i;
    assign bus.x         = x_q;
    assign bus.flag      = flag_q;

    assign sum     = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff    = {1'b0, bus.a} - {1'b0, bus.b};
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        alu_x = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.opcode)
            3'd0: begin
                alu_x = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (bus.a[M] == bus.b[M]) && (sum[M] != bus.a[M]);
            end
            3'd1: begin
                alu_x = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (bus.a[M] != bus.b[M]) && (diff[M] != bus.a[M]);
            end
            3'd2: alu_x = bus.a & bus.b;
            3'd3: alu_x = bus.a | bus.b;
            3'd4: alu_x = bus.a ^ bus.b;
            3'd5: begin
                alu_x = {bus.a[WIDTH-2:0], 1'b0};
                alu_c = bus.a[M];
            end
            3'd6: begin
                alu_x = {1'b0, bus.a[WIDTH-1:1]};
                alu_c = bus.a[0];
            end
            default: begin
                alu_x = '0;
                alu_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mul_start)
                    state_nxt = BUSY;
                else if (alu_load)
                    state_nxt = HOLD;
            end
            BUSY: begin
                if (cnt == '0)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (mul_start)
                    state_nxt = BUSY;
                else if (alu_load)
                    state_nxt = HOLD;
                else if (transfer)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Multiplier: cnt counts the remaining iterations down to terminal count 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (mul_start) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
        end else if (state == BUSY) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            flag_q <= '0;
        end else if (alu_load) begin
            x_q    <= alu_x;
            flag_q <= {alu_v, alu_c, alu_x[M], (alu_x == '0)};
        end else if (mul_done) begin
            x_q    <= acc_nxt[WIDTH-1:0];
            flag_q <= {1'b0, (acc_nxt[2*WIDTH-1:WIDTH] != '0), acc_nxt[M],
                       (acc_nxt[WIDTH-1:0] == '0)};
        end
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: a  input  WIDTH  operand A, sampled on accept.
REQ-005 Port: b  input  WIDTH  operand B, sampled on accept.
REQ-006 Port: opcode  input  3  operation select, sampled on accept.
REQ-007 Port: in_valid  input  1  a/b/opcode valid.
REQ-008 Port: in_ready  output  1  block can accept an operation this cycle.
REQ-009 Port: x  output  WIDTH  registered result.
REQ-010 Port: flag  output  4  registered flags: [0]=Z, [1]=N, [2]=C, [3]=V.
REQ-011 Port: out_valid  output  1  x/flag hold a result.
REQ-012 Port: out_ready  input  1  consumer takes result this cycle.

Function
REQ-013 Accept occurs on a rising edge with in_valid=1 and in_ready=1; operands and opcode are captured internally at accept.
REQ-014 Result transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-015 FSM states: IDLE, BUSY, HOLD.
REQ-016 IDLE: in_ready=1, out_valid=0; accept of opcode 0-6 -> HOLD; accept of opcode 7 -> BUSY.
REQ-017 BUSY: in_ready=0, out_valid=0; iterative multiply runs exactly WIDTH cycles, then -> HOLD with result loaded.
REQ-018 HOLD: out_valid=1, in_ready=out_ready (combinational); transfer without accept -> IDLE; transfer with accept -> HOLD (opcode 0-6) or BUSY (opcode 7); no transfer -> stay, x/flag stable.
REQ-019 Latency: opcode 0-6 out_valid asserts the cycle after accept; opcode 7 out_valid asserts WIDTH+1 cycles after accept.
REQ-020 Throughput: opcode 0-6 with out_ready held high sustain one result per cycle.
REQ-021 Op 0 ADD: x=(a+b) mod 2^WIDTH; C=carry out; V=signed overflow.
REQ-022 Op 1 SUB: x=(a-b) mod 2^WIDTH; C=1 when a<b unsigned (borrow); V=signed overflow.
REQ-023 Op 2 AND, op 3 OR, op 4 XOR: bitwise; C=0, V=0.
REQ-024 Op 5 SHL: x=a<<1, zero fill; C=a[WIDTH-1]; V=0.
REQ-025 Op 6 SHR: x=a>>1 logical; C=a[0]; V=0.
REQ-026 Op 7 MUL: unsigned shift-add, one partial-product bit per cycle; x=low WIDTH bits of a*b; C=1 when high WIDTH bits nonzero; V=0.
REQ-027 For all ops: Z=(x==0), N=x[WIDTH-1].
REQ-028 Input changes while not accepting (BUSY, HOLD without accept) have no effect on the result in progress.
REQ-029 x and flag change only when a new result is loaded; never while out_valid=1 and out_ready=0.

Reset
REQ-030 rst=1 forces state IDLE, out_valid=0, x=0, flag=0, multiply counter and accumulators 0, immediately and independent of clk.
REQ-031 in_ready=1 during and after reset.
REQ-032 Reset asserted mid-multiply (BUSY) or in HOLD discards the operation; no result is ever presented for it.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-033 a=10,b=5, opcodes 0..6 back-to-back one per cycle -> x=15,5,0,15,15,20,5 on consecutive cycles; flag=0 for all except AND (Z=1 -> flag=4'b0001).
REQ-034 SUB a=5,b=10 -> x=251, flag: N=1,C=1,V=0,Z=0; ADD a=127,b=1 -> x=128, N=1,V=1,C=0; ADD a=255,b=1 -> x=0, Z=1,C=1.
REQ-035 MUL a=10,b=5 -> in_ready=0 for 8 cycles, out_valid rises 9 cycles after accept, x=50, flag=0; MUL a=16,b=16 -> x=0, Z=1, C=1.
REQ-036 ADD 10+5 with out_ready=0 for 5 cycles -> x=15 and out_valid held, in_ready=0; drive a new ADD 1+1 in the cycle out_ready rises -> accepted that cycle, x=2 on the next.
REQ-037 Assert rst 3 cycles into MUL 10*5 -> out_valid=0, x=0, flag=0 immediately; after release no result appears until a new accept.
REQ-038 Regression at WIDTH=16: ADD 0xFFFF+1 -> x=0, Z=1, C=1; MUL 300*300 -> latency 17 cycles, x=0x5F90, C=1.
